// File: rtl/fprint_compare_if.sv
// Completion-report, comparator and CSR-result signals of the fingerprint compare scheduler.
// master = scheduler side, slave = surrounding fingerprint units / comparator / CSR block.
interface fprint_compare_if #(
  parameter int unsigned KEY_WIDTH = 4
);
  logic [1:0]           done_valid;
  logic [KEY_WIDTH-1:0] done_task0;
  logic [KEY_WIDTH-1:0] done_task1;
  logic                 cmp_req;
  logic [KEY_WIDTH-1:0] cmp_task;
  logic                 cmp_done;
  logic                 cmp_collision;
  logic                 comp_status_write;
  logic [KEY_WIDTH-1:0] comp_task;
  logic                 comp_collision_detected;
  logic                 comp_status_ack;

  modport master (
    input  done_valid, done_task0, done_task1, cmp_done, cmp_collision, comp_status_ack,
    output cmp_req, cmp_task, comp_status_write, comp_task, comp_collision_detected
  );

  modport slave (
    output done_valid, done_task0, done_task1, cmp_done, cmp_collision, comp_status_ack,
    input  cmp_req, cmp_task, comp_status_write, comp_task, comp_collision_detected
  );
endinterface

// File: rtl/fprint_compare_scheduler.sv
// Pairs per-task completion reports from two logical cores, queues matched tasks and
// sequences one fingerprint comparison at a time through the comparator to the CSR block.
module fprint_compare_scheduler #(
  parameter int unsigned KEY_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  fprint_compare_if.master            bus,
  input  logic                        flush,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] queue_count,
  output logic                        overrun_err,
  output logic                        overflow_err,
  output logic [KEY_WIDTH-1:0]        err_task
);
  localparam int unsigned NUM_TASKS = 2**KEY_WIDTH;
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CMP = 2'd1,
    REPORT   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_TASKS-1:0] pend0, pend1, pend0_next, pend1_next;
  logic [KEY_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, free_slots;
  logic [1:0]           valid;
  logic [KEY_WIDTH-1:0] task0, task1, err_task_next;
  logic                 push0, push1, acc0, acc1, pop;
  logic                 overrun0, overrun1, overrun_next, overflow_next;
  logic                 cmp_req_q, collision_q;
  logic [KEY_WIDTH-1:0] cmp_task_q;

  assign task0 = bus.done_task0;
  assign task1 = bus.done_task1;
  assign valid = bus.done_valid & {2{~flush}};

  // Core 1 sees core 0's same-cycle update, so equal keys from both cores pair up.
  always_comb begin
    pend0_next = pend0;
    pend1_next = pend1;
    push0      = 1'b0;
    push1      = 1'b0;
    overrun0   = 1'b0;
    overrun1   = 1'b0;
    if (valid[0]) begin
      if (pend0_next[task0]) begin
        overrun0 = 1'b1;
      end else if (pend1_next[task0]) begin
        pend1_next[task0] = 1'b0;
        push0             = 1'b1;
      end else begin
        pend0_next[task0] = 1'b1;
      end
    end
    if (valid[1]) begin
      if (pend1_next[task1]) begin
        overrun1 = 1'b1;
      end else if (pend0_next[task1]) begin
        pend0_next[task1] = 1'b0;
        push1             = 1'b1;
      end else begin
        pend1_next[task1] = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !flush) begin
          pop        = 1'b1;
          state_next = WAIT_CMP;
        end
      end
      WAIT_CMP: if (bus.cmp_done)        state_next = REPORT;
      REPORT:   if (bus.comp_status_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // A same-cycle pop frees its slot before pushes are admitted; core 0 is admitted first.
  always_comb begin
    free_slots    = CW'(FIFO_DEPTH) - count + CW'(pop);
    acc0          = push0 && (free_slots != '0);
    acc1          = push1 && (free_slots > CW'(acc0));
    overrun_next  = overrun_err | overrun0 | overrun1;
    overflow_next = overflow_err | (push0 & ~acc0) | (push1 & ~acc1);
    err_task_next = err_task;
    if (overrun0 || (push0 && !acc0)) err_task_next = task0;
    if (overrun1 || (push1 && !acc1)) err_task_next = task1;
  end

  always_ff @(posedge clk) begin
    if (acc0) fifo_mem[wr_ptr] <= task0;
    if (acc1) fifo_mem[wr_ptr + AW'(acc0)] <= task1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pend0        <= '0;
      pend1        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cmp_req_q    <= 1'b0;
      cmp_task_q   <= '0;
      collision_q  <= 1'b0;
      overrun_err  <= 1'b0;
      overflow_err <= 1'b0;
      err_task     <= '0;
    end else begin
      state     <= state_next;
      cmp_req_q <= pop;
      if (pop) cmp_task_q <= fifo_mem[rd_ptr];
      if (state == WAIT_CMP && bus.cmp_done) collision_q <= bus.cmp_collision;
      // Flush empties bookkeeping only; the compare/report in flight runs to completion.
      if (flush) begin
        pend0        <= '0;
        pend1        <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        count        <= '0;
        overrun_err  <= 1'b0;
        overflow_err <= 1'b0;
        err_task     <= '0;
      end else begin
        pend0        <= pend0_next;
        pend1        <= pend1_next;
        wr_ptr       <= wr_ptr + AW'(acc0) + AW'(acc1);
        rd_ptr       <= rd_ptr + AW'(pop);
        count        <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
        overrun_err  <= overrun_next;
        overflow_err <= overflow_next;
        err_task     <= err_task_next;
      end
    end
  end

  assign bus.cmp_req                 = cmp_req_q;
  assign bus.cmp_task                = cmp_task_q;
  assign bus.comp_task               = cmp_task_q;
  assign bus.comp_status_write       = (state == REPORT);
  assign bus.comp_collision_detected = collision_q;
  assign busy                        = (state != IDLE);
  assign queue_count                 = count;
endmodule

// File: tb/tb_fprint_compare_scheduler.sv
// Directed bench for fprint_compare_scheduler: pairing, queue order, overrun/overflow,
// long CSR back-pressure with flush and with reset.
module tb_fprint_compare_scheduler;
  localparam int unsigned KW = 4;
  localparam int unsigned FD = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          busy, overrun_err, overflow_err;
  logic [3:0]    queue_count;
  logic [KW-1:0] err_task;
  int            checks   = 0;
  int            failures = 0;

  fprint_compare_if #(.KEY_WIDTH(KW)) bus ();

  fprint_compare_scheduler #(.KEY_WIDTH(KW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .flush        (flush),
    .busy         (busy),
    .queue_count  (queue_count),
    .overrun_err  (overrun_err),
    .overflow_err (overflow_err),
    .err_task     (err_task)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic report(input logic v0, input logic [KW-1:0] t0,
                        input logic v1, input logic [KW-1:0] t1);
    bus.done_valid = {v1, v0};
    bus.done_task0 = t0;
    bus.done_task1 = t1;
    tick();
    bus.done_valid = 2'b00;
  endtask

  task automatic finish_cmp(input logic coll);
    bus.cmp_done      = 1'b1;
    bus.cmp_collision = coll;
    tick();
    bus.cmp_done      = 1'b0;
    bus.cmp_collision = 1'b0;
    check("report_write", 32'(bus.comp_status_write), 1);
    check("collision", 32'(bus.comp_collision_detected), 32'(coll));
    bus.comp_status_ack = 1'b1;
    tick();
    bus.comp_status_ack = 1'b0;
    check("write_drop", 32'(bus.comp_status_write), 0);
    check("idle_after_ack", 32'(busy), 0);
  endtask

  task automatic serve(input logic [KW-1:0] exp_task, input logic coll);
    int unsigned n = 0;
    while (bus.cmp_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("issue_seen", 32'(bus.cmp_req), 1);
    check("cmp_task", 32'(bus.cmp_task), 32'(exp_task));
    check("comp_task", 32'(bus.comp_task), 32'(exp_task));
    finish_cmp(coll);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.done_valid      = 2'b00;
    bus.done_task0      = '0;
    bus.done_task1      = '0;
    bus.cmp_done        = 1'b0;
    bus.cmp_collision   = 1'b0;
    bus.comp_status_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_cmp_req", 32'(bus.cmp_req), 0);
    check("rst_write", 32'(bus.comp_status_write), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(queue_count), 0);
    check("rst_overrun", 32'(overrun_err), 0);
    check("rst_overflow", 32'(overflow_err), 0);

    // Basic pair: core0 task 3 at cycle 0, core1 task 3 at cycle 5, issue at cycle 7.
    report(1'b1, 4'd3, 1'b0, 4'd0);
    repeat (4) tick();
    report(1'b0, 4'd0, 1'b1, 4'd3);
    check("t1_count", 32'(queue_count), 1);
    check("t1_no_req_yet", 32'(bus.cmp_req), 0);
    tick();
    check("t1_req", 32'(bus.cmp_req), 1);
    check("t1_task", 32'(bus.cmp_task), 3);
    check("t1_popped", 32'(queue_count), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_req_pulse", 32'(bus.cmp_req), 0);
    bus.cmp_done = 1'b1; bus.cmp_collision = 1'b1;
    tick();
    bus.cmp_done = 1'b0; bus.cmp_collision = 1'b0;
    check("t1_write", 32'(bus.comp_status_write), 1);
    check("t1_coll", 32'(bus.comp_collision_detected), 1);
    repeat (3) tick();
    check("t1_write_hold", 32'(bus.comp_status_write), 1);
    bus.comp_status_ack = 1'b1;
    tick();
    bus.comp_status_ack = 1'b0;
    check("t1_write_off", 32'(bus.comp_status_write), 0);
    check("t1_idle", 32'(busy), 0);
    bus.cmp_done = 1'b1;
    tick();
    bus.cmp_done = 1'b0;
    check("t1_done_ignored", 32'(busy), 0);

    // Same-cycle same key: one entry, no pending bit on either core.
    report(1'b1, 4'd5, 1'b1, 4'd5);
    check("t2_count", 32'(queue_count), 1);
    serve(4'd5, 1'b0);
    report(1'b0, 4'd0, 1'b1, 4'd5);
    check("t2_no_pend0", 32'(queue_count), 0);
    report(1'b1, 4'd5, 1'b0, 4'd0);
    check("t2_no_pend1", 32'(queue_count), 1);
    serve(4'd5, 1'b0);

    // Cross pairs resolved in one cycle: core0's key queued first.
    report(1'b1, 4'd2, 1'b0, 4'd0);
    report(1'b0, 4'd0, 1'b1, 4'd7);
    check("t3_no_match", 32'(queue_count), 0);
    report(1'b1, 4'd7, 1'b1, 4'd2);
    check("t3_count", 32'(queue_count), 2);
    serve(4'd7, 1'b1);
    serve(4'd2, 1'b0);

    // Overrun on core 0.
    report(1'b1, 4'd9, 1'b0, 4'd0);
    check("t4_no_overrun", 32'(overrun_err), 0);
    report(1'b1, 4'd9, 1'b0, 4'd0);
    check("t4_overrun", 32'(overrun_err), 1);
    check("t4_err_task", 32'(err_task), 9);
    check("t4_count", 32'(queue_count), 0);
    report(1'b0, 4'd0, 1'b1, 4'd9);
    check("t4_pend_kept", 32'(queue_count), 1);
    serve(4'd9, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_err", 32'(overrun_err), 0);

    // Fill the queue with the comparator stalled, then overflow.
    report(1'b1, 4'd14, 1'b0, 4'd0);
    report(1'b0, 4'd0, 1'b1, 4'd15);
    for (int k = 0; k < 8; k++) report(1'b1, 4'(k), 1'b1, 4'(k));
    check("t5_count7", 32'(queue_count), 7);
    check("t5_busy", 32'(busy), 1);
    check("t5_inflight", 32'(bus.cmp_task), 0);
    check("t5_no_ovf", 32'(overflow_err), 0);
    report(1'b1, 4'd15, 1'b1, 4'd14);
    check("t5_one_slot_count", 32'(queue_count), 8);
    check("t5_one_slot_ovf", 32'(overflow_err), 1);
    check("t5_one_slot_err", 32'(err_task), 14);
    report(1'b1, 4'd12, 1'b1, 4'd12);
    check("t5_ovf", 32'(overflow_err), 1);
    check("t5_err_task", 32'(err_task), 12);
    check("t5_full", 32'(queue_count), 8);
    finish_cmp(1'b0);
    report(1'b1, 4'd13, 1'b1, 4'd13);
    check("t5_push_pop_full", 32'(queue_count), 8);
    check("t5_push_pop_req", 32'(bus.cmp_req), 1);
    for (int k = 1; k < 8; k++) serve(4'(k), 1'b0);
    serve(4'd15, 1'b0);
    serve(4'd13, 1'b0);
    check("t5_drained", 32'(queue_count), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_ovf", 32'(overflow_err), 0);

    // CSR back-pressure with flush mid-report.
    report(1'b1, 4'd6, 1'b0, 4'd0);
    report(1'b1, 4'd4, 1'b1, 4'd4);
    tick();
    check("t6_req", 32'(bus.cmp_req), 1);
    check("t6_task", 32'(bus.cmp_task), 4);
    report(1'b1, 4'd10, 1'b1, 4'd10);
    check("t6_queued", 32'(queue_count), 1);
    bus.cmp_done = 1'b1; bus.cmp_collision = 1'b1;
    tick();
    bus.cmp_done = 1'b0; bus.cmp_collision = 1'b0;
    repeat (10) tick();
    check("t6_hold_a", 32'(bus.comp_status_write), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_write", 32'(bus.comp_status_write), 1);
    check("t6_flush_busy", 32'(busy), 1);
    check("t6_flush_count", 32'(queue_count), 0);
    check("t6_flush_coll", 32'(bus.comp_collision_detected), 1);
    repeat (10) tick();
    check("t6_hold_b", 32'(bus.comp_status_write), 1);
    bus.comp_status_ack = 1'b1;
    tick();
    bus.comp_status_ack = 1'b0;
    check("t6_write_off", 32'(bus.comp_status_write), 0);
    check("t6_idle", 32'(busy), 0);
    tick();
    tick();
    check("t6_no_issue", 32'(bus.cmp_req), 0);
    report(1'b0, 4'd0, 1'b1, 4'd6);
    check("t6_pend_cleared", 32'(queue_count), 0);
    report(1'b1, 4'd6, 1'b0, 4'd0);
    check("t6_repair", 32'(queue_count), 1);
    serve(4'd6, 1'b0);

    // Same back-pressure sequence ended by reset.
    report(1'b1, 4'd6, 1'b0, 4'd0);
    report(1'b1, 4'd6, 1'b0, 4'd0);
    check("t7_overrun", 32'(overrun_err), 1);
    report(1'b1, 4'd4, 1'b1, 4'd4);
    tick();
    check("t7_req", 32'(bus.cmp_req), 1);
    report(1'b1, 4'd10, 1'b1, 4'd10);
    bus.cmp_done = 1'b1; bus.cmp_collision = 1'b1;
    tick();
    bus.cmp_done = 1'b0; bus.cmp_collision = 1'b0;
    repeat (10) tick();
    check("t7_hold", 32'(bus.comp_status_write), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_cmp_req", 32'(bus.cmp_req), 0);
    check("t7_cmp_task", 32'(bus.cmp_task), 0);
    check("t7_write", 32'(bus.comp_status_write), 0);
    check("t7_comp_task", 32'(bus.comp_task), 0);
    check("t7_coll", 32'(bus.comp_collision_detected), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_count", 32'(queue_count), 0);
    check("t7_overrun_clr", 32'(overrun_err), 0);
    check("t7_overflow_clr", 32'(overflow_err), 0);
    check("t7_err_task", 32'(err_task), 0);
    report(1'b0, 4'd0, 1'b1, 4'd6);
    check("t7_pend_cleared", 32'(queue_count), 0);
    tick();
    check("t7_no_issue", 32'(bus.cmp_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fprint_compare_scheduler.md
# fprint_compare_scheduler

Schedules fingerprint comparisons for redundant task pairs. It tracks per-task completion reports from the two logical cores. When both copies of a task have completed, it queues the task, then sequences one comparison at a time through the comparator and delivers the result to the comparator CSR block over the `comp_status_write`/`comp_status_ack` handshake. It sits between the fingerprint units (completion reports), the comparator core and the CSR register block.

## Interface
- `KEY_WIDTH`, default 4: task key width; the block tracks `2**KEY_WIDTH` tasks.
- `FIFO_DEPTH`, default 8: ready-queue depth; must be a power of 2, ≥2.

- `clk`  in  1  clock; the block uses a single clock.
- `reset`  in  1  reset; synchronous and active-high.
- `done_valid`  in  2  one-cycle completion strobe, bit c = logical core c.
- `done_task0`  in  KEY_WIDTH  task key reported by core 0.
- `done_task1`  in  KEY_WIDTH  task key reported by core 1.
- `flush`  in  1  synchronous clear of pending bits, queue and error flags.
- `cmp_req`  out  1  one-cycle compare start pulse.
- `cmp_task`  out  KEY_WIDTH  task being compared; held from `cmp_req` until the report completes.
- `cmp_done`  in  1  comparator finished (one-cycle pulse).
- `cmp_collision`  in  1  mismatch result, valid with `cmp_done`.
- `comp_status_write`  out  1  result-delivery request to the CSR block.
- `comp_task`  out  KEY_WIDTH  task key of the result.
- `comp_collision_detected`  out  1  latched `cmp_collision`.
- `comp_status_ack`  in  1  CSR accepted the result.
- `busy`  out  1  FSM not in IDLE.
- `queue_count`  out  log2(FIFO_DEPTH)+1  queued entries.
- `overrun_err`  out  1  sticky: a core reported a task that was already pending for that same core.
- `overflow_err`  out  1  sticky: a pair matched while the queue was full.
- `err_task`  out  KEY_WIDTH  key of the most recent error event.

## Operation
- Pending state: two bit vectors `pend[c][2**KEY_WIDTH]`.
- Each cycle, core 0's strobe is processed first, then core 1's.
- Report from core c for task t:
  - If `pend[c][t]` is already set: set `overrun_err`, set `err_task`=t, no other change.
  - Else if `pend[1-c][t]` is set: a match. Clear `pend[1-c][t]` and push t.
  - Else: set `pend[c][t]`.
- Both cores reporting the same t in the same cycle is a match: one push, no pending bits set.
- Two matches on distinct tasks in the same cycle: two pushes, core 0's task first.
- Push when the queue is full: drop the task, set `overflow_err`, set `err_task`=t.
  - If only one slot is free, core 0's push wins and core 1's push overflows.
- Queue: FIFO with 0–2 pushes and 0–1 pop per cycle. A push and a pop in the same cycle on a full queue is legal: the pop frees the slot first.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into `cmp_task`, assert `cmp_req` for 1 cycle, go to WAIT_CMP.
  - WAIT_CMP: on `cmp_done`, latch `cmp_collision` into `comp_collision_detected`, go to REPORT.
  - REPORT: `comp_status_write`=1. On a sampled `comp_status_ack`=1, go to IDLE; `comp_status_write` is 0 from the next cycle.
- The block waits indefinitely in WAIT_CMP and REPORT (the CSR block withholds the ack while its interrupt is pending). There is no timeout.
- `flush`:
  - Clears the pending vectors, the queue and the error flags.
  - Does not abort an in-flight compare or report.
  - Same-cycle `done_valid` reports are discarded.
- `reset`: every output returns to 0, the FSM goes to IDLE, and the pending vectors and queue are cleared.

## Timing
- Completion-to-queue: a match in cycle N makes `queue_count` increase at N+1.
- Queue-to-issue: with the FSM in IDLE and the queue non-empty at edge N, `cmp_req`=1 during N+1.
- Minimum turnaround from `cmp_req` to the next `cmp_req` is 4 cycles: issue, then `cmp_done` the next cycle, then ack one cycle into REPORT, then IDLE.
- `cmp_done` outside WAIT_CMP is ignored.
- `comp_status_ack` outside REPORT is ignored.
- `comp_task` always equals `cmp_task`.
- Error flags set in the cycle after the causing report.

## Test plan
- Core0 reports task 3 at cycle 0, core1 reports task 3 at cycle 5 -> `cmp_req` at cycle 7 with `cmp_task`=3. Comparator returns `cmp_done`, `cmp_collision`=1 -> `comp_status_write`=1 and `comp_collision_detected`=1 until ack, then `busy`=0.
- Same cycle: core0 reports 5, core1 reports 5 -> exactly one queue entry (5), no pending bits left.
- Cross pairs: pend0 holds 2, pend1 holds 7; same cycle core0 reports 7 and core1 reports 2 -> `queue_count`+2; issue order 7 then 2.
- Core0 reports task 9 twice without a core1 report -> `overrun_err`=1, `err_task`=9, and the single pending bit remains.
- Hold `cmp_done` low and fill the queue to 8 entries; complete one more pair (task 12) -> `overflow_err`=1, `err_task`=12, `queue_count`=8.
- In REPORT, hold `comp_status_ack` low for 20 cycles -> `comp_status_write` stays 1. Assert `flush` mid-way -> report still completes after ack; queue and pending vectors empty afterwards. Repeat the same sequence with `reset` -> all outputs 0 the next cycle.
